// File: rtl/adc_capture_buffer.sv
// Pre/post-trigger ADC capture into a circular block RAM. Captures DEPTH samples
// with the trigger sample at logical index pretrig_len; readable by logical index.
module adc_capture_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_data,
  input  logic                  arm,
  input  logic                  trigger,
  input  logic [ADDR_WIDTH-1:0] pretrig_len,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] start_addr,
  output logic                  busy,
  output logic                  waiting,
  output logic                  done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_WAIT_TRIG,
    S_POST,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_fill_cnt;
  logic [ADDR_WIDTH-1:0] r_post_cnt;
  logic [ADDR_WIDTH-1:0] r_pretrig;
  logic [ADDR_WIDTH-1:0] r_start_addr;
  logic                  r_busy;
  logic                  r_waiting;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_rd_phys;

  assign w_wr_en   = sample_valid &&
                     (r_state == S_FILL || r_state == S_WAIT_TRIG || r_state == S_POST);
  assign w_rd_phys = r_start_addr + rd_addr;

  // NOTE: the RAM has no reset so it maps onto block RAM; a reset would force it into flops.
  always_ff @(posedge clock) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= sample_data;
  end

  // Read-before-write falls out of the non-blocking update: a same-address read sees old data.
  always_ff @(posedge clock) begin
    if (reset) r_rd_data <= '0;
    else       r_rd_data <= r_mem[w_rd_phys];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values and the block behaves like flops regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_fill_cnt   <= '0;
      r_post_cnt   <= '0;
      r_pretrig    <= '0;
      r_start_addr <= '0;
      r_busy       <= 1'b0;
      r_waiting    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + ADDR_ONE;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (arm) begin
            r_pretrig  <= pretrig_len;
            r_wr_ptr   <= '0;
            r_fill_cnt <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            if (pretrig_len == '0) begin
              r_state   <= S_WAIT_TRIG;
              r_waiting <= 1'b1;
            end else begin
              r_state   <= S_FILL;
              r_waiting <= 1'b0;
            end
          end
        end

        S_FILL: begin
          if (sample_valid) begin
            r_fill_cnt <= r_fill_cnt + ADDR_ONE;
            if (r_fill_cnt + ADDR_ONE == r_pretrig) begin
              r_state   <= S_WAIT_TRIG;
              r_waiting <= 1'b1;
            end
          end
        end

        S_WAIT_TRIG: begin
          if (sample_valid && trigger) begin
            // The trigger sample lands at r_wr_ptr; DEPTH-1-pretrig writes remain.
            r_start_addr <= r_wr_ptr - r_pretrig;
            r_post_cnt   <= ~r_pretrig;
            r_waiting    <= 1'b0;
            if (r_pretrig == '1) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_POST;
            end
          end
        end

        S_POST: begin
          if (sample_valid) begin
            r_post_cnt <= r_post_cnt - ADDR_ONE;
            if (r_post_cnt == ADDR_ONE) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_data    = r_rd_data;
  assign start_addr = r_start_addr;
  assign busy       = r_busy;
  assign waiting    = r_waiting;
  assign done       = r_done;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Directed bench for adc_capture_buffer at DEPTH=16: capture windows, boundary
// pretrig lengths, ignored arm/trigger, reset abort and RAM read-back.
module tb_adc_capture_buffer;

  logic       clock = 1'b0;
  logic       reset;
  logic       sample_valid;
  logic [7:0] sample_data;
  logic       arm;
  logic       trigger;
  logic [3:0] pretrig_len;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic [3:0] start_addr;
  logic       busy;
  logic       waiting;
  logic       done;

  int checks = 0;
  int errors = 0;

  adc_capture_buffer #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clock        (clock),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .arm          (arm),
    .trigger      (trigger),
    .pretrig_len  (pretrig_len),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .start_addr   (start_addr),
    .busy         (busy),
    .waiting      (waiting),
    .done         (done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic t);
    sample_valid = 1'b1;
    sample_data  = d;
    trigger      = t;
    tick();
    sample_valid = 1'b0;
    trigger      = 1'b0;
  endtask

  task automatic do_arm(input logic [3:0] len);
    pretrig_len = len;
    arm         = 1'b1;
    tick();
    arm         = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; arm = 1'b1; sample_valid = 1'b1; trigger = 1'b1;
    sample_data = 8'h00; pretrig_len = 4'd0; rd_addr = 4'd0;
    tick(); tick();
    reset = 1'b0; arm = 1'b0; sample_valid = 1'b0; trigger = 1'b0;
    checks++;
    if ({busy, waiting, done} !== 3'b000) begin
      errors++; $display("FAIL reset_status got %b exp 000", {busy, waiting, done});
    end
    checks++;
    if (start_addr !== 4'd0) begin
      errors++; $display("FAIL reset_start got %0d exp 0", start_addr);
    end
    checks++;
    if (rd_data !== 8'h00) begin
      errors++; $display("FAIL reset_rd_data got %h exp 00", rd_data);
    end
  endtask

  // pretrig 4, trigger on sample 10; also trigger-in-FILL, trigger-without-valid, arm-in-POST.
  task automatic test_pretrig4();
    do_arm(4'd4);
    checks++;
    if ({busy, waiting, done} !== 3'b100) begin
      errors++; $display("FAIL p4_armed got %b exp 100", {busy, waiting, done});
    end
    for (int k = 0; k < 3; k++) send(8'(k), 1'b1);
    checks++;
    if ({busy, waiting, done} !== 3'b100) begin
      errors++; $display("FAIL p4_fill_trig_ignored got %b exp 100", {busy, waiting, done});
    end
    send(8'd3, 1'b1);
    checks++;
    if ({busy, waiting, done} !== 3'b110) begin
      errors++; $display("FAIL p4_waiting got %b exp 110", {busy, waiting, done});
    end
    for (int k = 4; k < 10; k++) send(8'(k), 1'b0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    checks++;
    if ({busy, waiting, done} !== 3'b110) begin
      errors++; $display("FAIL p4_trig_no_valid got %b exp 110", {busy, waiting, done});
    end
    send(8'd10, 1'b1);
    checks++;
    if ({busy, waiting, done} !== 3'b100) begin
      errors++; $display("FAIL p4_post got %b exp 100", {busy, waiting, done});
    end
    checks++;
    if (start_addr !== 4'd6) begin
      errors++; $display("FAIL p4_start got %0d exp 6", start_addr);
    end
    do_arm(4'd9);
    checks++;
    if ({busy, waiting, done} !== 3'b100) begin
      errors++; $display("FAIL p4_arm_in_post got %b exp 100", {busy, waiting, done});
    end
    for (int k = 11; k < 21; k++) send(8'(k), 1'b0);
    checks++;
    if ({busy, waiting, done} !== 3'b100) begin
      errors++; $display("FAIL p4_not_done_early got %b exp 100", {busy, waiting, done});
    end
    send(8'd21, 1'b0);
    checks++;
    if ({busy, waiting, done} !== 3'b001) begin
      errors++; $display("FAIL p4_done got %b exp 001", {busy, waiting, done});
    end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      tick();
      checks++;
      if (rd_data !== 8'(6 + i)) begin
        errors++; $display("FAIL p4_read[%0d] got %h exp %h", i, rd_data, 8'(6 + i));
      end
    end
  endtask

  // Re-arm from DONE with pretrig 0; also same-address read during write returns old data.
  task automatic test_rearm_zero();
    rd_addr = 4'd10;
    do_arm(4'd0);
    checks++;
    if ({busy, waiting, done} !== 3'b110) begin
      errors++; $display("FAIL p0_skip_fill got %b exp 110", {busy, waiting, done});
    end
    send(8'h40, 1'b1);
    checks++;
    if (rd_data !== 8'h10) begin
      errors++; $display("FAIL p0_read_old got %h exp 10", rd_data);
    end
    checks++;
    if (start_addr !== 4'd0) begin
      errors++; $display("FAIL p0_start got %0d exp 0", start_addr);
    end
    for (int k = 1; k < 15; k++) send(8'h40 + 8'(k), 1'b0);
    checks++;
    if ({busy, waiting, done} !== 3'b100) begin
      errors++; $display("FAIL p0_not_done_early got %b exp 100", {busy, waiting, done});
    end
    send(8'h4F, 1'b0);
    checks++;
    if ({busy, waiting, done} !== 3'b001) begin
      errors++; $display("FAIL p0_done got %b exp 001", {busy, waiting, done});
    end
    rd_addr = 4'd0; tick();
    checks++;
    if (rd_data !== 8'h40) begin
      errors++; $display("FAIL p0_read0 got %h exp 40", rd_data);
    end
    rd_addr = 4'd15; tick();
    checks++;
    if (rd_data !== 8'h4F) begin
      errors++; $display("FAIL p0_read15 got %h exp 4f", rd_data);
    end
  endtask

  // pretrig 15: trigger write goes straight to DONE.
  task automatic test_pretrig15();
    do_arm(4'd15);
    for (int k = 0; k < 14; k++) send(8'h80 + 8'(k), 1'b0);
    checks++;
    if ({busy, waiting, done} !== 3'b100) begin
      errors++; $display("FAIL p15_fill got %b exp 100", {busy, waiting, done});
    end
    send(8'h8E, 1'b0);
    checks++;
    if ({busy, waiting, done} !== 3'b110) begin
      errors++; $display("FAIL p15_waiting got %b exp 110", {busy, waiting, done});
    end
    send(8'h8F, 1'b1);
    checks++;
    if ({busy, waiting, done} !== 3'b001) begin
      errors++; $display("FAIL p15_done_direct got %b exp 001", {busy, waiting, done});
    end
    checks++;
    if (start_addr !== 4'd0) begin
      errors++; $display("FAIL p15_start got %0d exp 0", start_addr);
    end
    rd_addr = 4'd15; tick();
    checks++;
    if (rd_data !== 8'h8F) begin
      errors++; $display("FAIL p15_read15 got %h exp 8f", rd_data);
    end
    rd_addr = 4'd0; tick();
    checks++;
    if (rd_data !== 8'h80) begin
      errors++; $display("FAIL p15_read0 got %h exp 80", rd_data);
    end
  endtask

  // Reset mid-POST aborts, keeps RAM, and a fresh capture then completes.
  task automatic test_reset_mid_post();
    do_arm(4'd2);
    send(8'hC0, 1'b0);
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b1);
    send(8'hC4, 1'b0);
    send(8'hC5, 1'b0);
    checks++;
    if (start_addr !== 4'd1) begin
      errors++; $display("FAIL rst_pre_start got %0d exp 1", start_addr);
    end
    reset = 1'b1; arm = 1'b1; sample_valid = 1'b1; trigger = 1'b1;
    tick();
    reset = 1'b0; arm = 1'b0; sample_valid = 1'b0; trigger = 1'b0;
    checks++;
    if ({busy, waiting, done, start_addr, rd_data} !== 15'd0) begin
      errors++; $display("FAIL rst_abort got %b/%0d/%h exp 000/0/00",
                         {busy, waiting, done}, start_addr, rd_data);
    end
    rd_addr = 4'd10; tick();
    checks++;
    if (rd_data !== 8'h8A) begin
      errors++; $display("FAIL rst_ram_kept got %h exp 8a", rd_data);
    end
    do_arm(4'd3);
    for (int k = 0; k < 17; k++) send(8'hD0 + 8'(k), 1'(k == 5));
    checks++;
    if ({busy, waiting, done} !== 3'b100) begin
      errors++; $display("FAIL rst_recap_post got %b exp 100", {busy, waiting, done});
    end
    send(8'hE1, 1'b0);
    checks++;
    if ({busy, waiting, done} !== 3'b001) begin
      errors++; $display("FAIL rst_recap_done got %b exp 001", {busy, waiting, done});
    end
    checks++;
    if (start_addr !== 4'd2) begin
      errors++; $display("FAIL rst_recap_start got %0d exp 2", start_addr);
    end
    rd_addr = 4'd0; tick();
    checks++;
    if (rd_data !== 8'hD2) begin
      errors++; $display("FAIL rst_recap_read0 got %h exp d2", rd_data);
    end
    rd_addr = 4'd3; tick();
    checks++;
    if (rd_data !== 8'hD5) begin
      errors++; $display("FAIL rst_recap_read3 got %h exp d5", rd_data);
    end
    rd_addr = 4'd14; tick();
    checks++;
    if (rd_data !== 8'hE0) begin
      errors++; $display("FAIL rst_recap_read14 got %h exp e0", rd_data);
    end
    rd_addr = 4'd15; tick();
    checks++;
    if (rd_data !== 8'hE1) begin
      errors++; $display("FAIL rst_recap_read15 got %h exp e1", rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_pretrig4();
    test_rearm_zero();
    test_pretrig15();
    test_reset_mid_post();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
